// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential divider
//
// Purpose: state encoding and constants used by div_unit and div_step.
// Ports:   none (package).
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } divState_t;

  localparam int DIV_WIDTH      = 32;
  localparam int DIV_ITERATIONS = 32;

  // Result written to both HI and LO on divide-by-zero.
  localparam logic [DIV_WIDTH-1:0] DIV0_RESULT = '1;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
//
// Purpose: shifts {rem,quo} left by one, trial-subtracts the divisor,
//          restores on borrow and shifts the new quotient bit into quo.
// Ports:   remIn/quoIn   partial remainder and quotient (magnitudes)
//          divisor       divisor magnitude
//          remOut/quoOut values after this iteration
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] remIn,
  input  logic [WIDTH-1:0] quoIn,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remOut,
  output logic [WIDTH-1:0] quoOut
);

  // One extra bit: the shifted remainder can reach 2*divisor-1, and the
  // top bit of the trial difference is the borrow.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           borrow;

  always_comb begin
    shifted = {remIn, quoIn[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    borrow  = trial[WIDTH];
    remOut  = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quoOut  = {quoIn[WIDTH-2:0], ~borrow};
  end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - sequential signed divider, one quotient bit per clock
//
// Purpose: signed WIDTH-bit division for the div instruction. Quotient goes
//          to LO (truncated toward zero), remainder to HI (dividend's sign).
//          Divide-by-zero gives HI=LO=all ones and raises Div0.
// Ports:   clk, reset (async, active low)
//          RegAOut dividend, RegBOut divisor (two's complement)
//          DivCtrl request level, 4-phase handshake with DivDone
//          DivDone result valid (held in DONE), Div0 divide-by-zero flag
//          HI remainder, LO quotient
//          DivOvf (only with DIV_OVF_FLAG_EN) flags -2^31 / -1
// Config:  `define DIV_OVF_FLAG_EN adds the DivOvf output.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] RegAOut,
  input  logic [WIDTH-1:0] RegBOut,
  input  logic             DivCtrl,
  output logic             DivDone,
  output logic             Div0,
`ifdef DIV_OVF_FLAG_EN
  output logic             DivOvf,
`endif
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CNT_W = $clog2(DIV_ITERATIONS + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_ITERATIONS);

  divState_t        state, nextState;
  logic [CNT_W-1:0] iterCount;
  logic [WIDTH-1:0] remReg, quoReg, divisorMag;
  logic [WIDTH-1:0] stepRem, stepQuo;
  logic [WIDTH-1:0] aMag, bMag;
  logic             negQuo, negRem, div0Reg;
`ifdef DIV_OVF_FLAG_EN
  logic             ovfReg;
`endif

  // Two's-complement magnitude; -2^31 maps to unsigned 0x80000000.
  assign aMag = RegAOut[WIDTH-1] ? -RegAOut : RegAOut;
  assign bMag = RegBOut[WIDTH-1] ? -RegBOut : RegBOut;

  div_step #(.WIDTH(WIDTH)) uStep (
    .remIn  (remReg),
    .quoIn  (quoReg),
    .divisor(divisorMag),
    .remOut (stepRem),
    .quoOut (stepQuo)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  // RUN holds for LAST_ITER iterations plus one more edge that applies the
  // sign fix-up and registers HI/LO on the way into DONE.
  always_comb begin
    nextState = state;
    DivDone   = 1'b0;
    Div0      = 1'b0;
`ifdef DIV_OVF_FLAG_EN
    DivOvf    = 1'b0;
`endif
    case (state)
      IDLE: if (DivCtrl) nextState = (RegBOut == '0) ? DONE : RUN;
      RUN:  if (iterCount == LAST_ITER) nextState = DONE;
      DONE: begin
        DivDone = 1'b1;
        Div0    = div0Reg;
`ifdef DIV_OVF_FLAG_EN
        DivOvf  = ovfReg;
`endif
        if (!DivCtrl) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iterCount  <= '0;
      remReg     <= '0;
      quoReg     <= '0;
      divisorMag <= '0;
      negQuo     <= 1'b0;
      negRem     <= 1'b0;
      div0Reg    <= 1'b0;
      HI         <= '0;
      LO         <= '0;
`ifdef DIV_OVF_FLAG_EN
      ovfReg     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (DivCtrl) begin
          if (RegBOut == '0) begin
            div0Reg <= 1'b1;
            HI      <= DIV0_RESULT;
            LO      <= DIV0_RESULT;
          end else begin
            div0Reg    <= 1'b0;
            remReg     <= '0;
            quoReg     <= aMag;
            divisorMag <= bMag;
            negQuo     <= RegAOut[WIDTH-1] ^ RegBOut[WIDTH-1];
            negRem     <= RegAOut[WIDTH-1];
            iterCount  <= '0;
          end
`ifdef DIV_OVF_FLAG_EN
          ovfReg <= (RegAOut == {1'b1, {(WIDTH-1){1'b0}}}) && (RegBOut == '1);
`endif
        end
        RUN: begin
          if (iterCount == LAST_ITER) begin
            LO <= negQuo ? -quoReg : quoReg;
            HI <= negRem ? -remReg : remReg;
          end else begin
            remReg    <= stepRem;
            quoReg    <= stepQuo;
            iterCount <= iterCount + 1'b1;
          end
        end
        DONE: if (!DivCtrl) begin
          div0Reg <= 1'b0;
`ifdef DIV_OVF_FLAG_EN
          ovfReg  <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] RegAOut, RegBOut;
  logic        DivCtrl;
  logic        DivDone, Div0;
  logic [31:0] HI, LO;
`ifdef DIV_OVF_FLAG_EN
  logic        DivOvf;
`endif

  int errCount   = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  div_unit dut (
    .clk    (clk),
    .reset  (reset),
    .RegAOut(RegAOut),
    .RegBOut(RegBOut),
    .DivCtrl(DivCtrl),
    .DivDone(DivDone),
    .Div0   (Div0),
`ifdef DIV_OVF_FLAG_EN
    .DivOvf (DivOvf),
`endif
    .HI     (HI),
    .LO     (LO)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Runs one division. dropAt>0 deasserts DivCtrl after that many edges;
  // changeAt>0 scrambles the operand inputs after that many edges.
  task automatic runDiv(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expLo, input logic [31:0] expHi,
                        input logic expDiv0, input logic expOvf, input int expLat,
                        input int dropAt, input int changeAt);
    int edges;
    @(negedge clk);
    RegAOut = a;
    RegBOut = b;
    DivCtrl = 1'b1;
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
      if (edges == dropAt) DivCtrl = 1'b0;
      if (edges == changeAt) begin
        RegAOut = 32'h1;
        RegBOut = 32'h0;
      end
    end while (!DivDone && edges < 100);
    checkVal({tag, " latency"}, edges, expLat);
    checkVal({tag, " DivDone"}, {31'b0, DivDone}, 32'd1);
    checkVal({tag, " LO"}, LO, expLo);
    checkVal({tag, " HI"}, HI, expHi);
    checkVal({tag, " Div0"}, {31'b0, Div0}, {31'b0, expDiv0});
`ifdef DIV_OVF_FLAG_EN
    checkVal({tag, " DivOvf"}, {31'b0, DivOvf}, {31'b0, expOvf});
`else
    if (expOvf) checkVal({tag, " ovf-unbuilt"}, {31'b0, DivDone}, 32'd1);
`endif
    if (dropAt == 0) begin
      repeat (2) @(posedge clk);
      #1 checkVal({tag, " held DivDone"}, {31'b0, DivDone}, 32'd1);
      DivCtrl = 1'b0;
    end
    @(posedge clk); #1;
    checkVal({tag, " released DivDone"}, {31'b0, DivDone}, 32'd0);
    checkVal({tag, " released Div0"}, {31'b0, Div0}, 32'd0);
    checkVal({tag, " idle LO hold"}, LO, expLo);
    checkVal({tag, " idle HI hold"}, HI, expHi);
`ifdef DIV_OVF_FLAG_EN
    checkVal({tag, " released DivOvf"}, {31'b0, DivOvf}, 32'd0);
`endif
  endtask

  initial begin
    reset   = 1'b0;
    DivCtrl = 1'b0;
    RegAOut = 32'd0;
    RegBOut = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checkVal("reset DivDone", {31'b0, DivDone}, 32'd0);
    checkVal("reset Div0", {31'b0, Div0}, 32'd0);
    checkVal("reset HI", HI, 32'd0);
    checkVal("reset LO", LO, 32'd0);
    @(negedge clk) reset = 1'b1;

    runDiv("10/3",      32'd10,        32'd3,         32'd3,         32'd1,         1'b0, 1'b0, 34, 0, 0);
    runDiv("5/0",       32'd5,         32'd0,         32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1, 1'b0, 1,  0, 0);
    runDiv("-10/3",     32'hFFFFFFF6,  32'd3,         32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0, 1'b0, 34, 0, 0);
    runDiv("10/-3",     32'd10,        32'hFFFFFFFD,  32'hFFFFFFFD,  32'd1,         1'b0, 1'b0, 34, 0, 0);
    runDiv("-10/-3",    32'hFFFFFFF6,  32'hFFFFFFFD,  32'd3,         32'hFFFFFFFF,  1'b0, 1'b0, 34, 0, 0);
    runDiv("12/4",      32'd12,        32'd4,         32'd3,         32'd0,         1'b0, 1'b0, 34, 0, 0);
    runDiv("min/-1",    32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0, 1'b1, 34, 0, 0);
    runDiv("7/9",       32'd7,         32'd9,         32'd0,         32'd7,         1'b0, 1'b0, 34, 0, 0);
    runDiv("opchange",  32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 1'b0, 34, 0, 5);
    runDiv("earlydrop", 32'd50,        32'd6,         32'd8,         32'd2,         1'b0, 1'b0, 34, 3, 0);

    // Reset in the middle of RUN clears outputs without waiting for a clock edge.
    @(negedge clk);
    RegAOut = 32'd100;
    RegBOut = 32'd7;
    DivCtrl = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset   = 1'b0;
    DivCtrl = 1'b0;
    #1;
    checkVal("midrun reset DivDone", {31'b0, DivDone}, 32'd0);
    checkVal("midrun reset HI", HI, 32'd0);
    checkVal("midrun reset LO", LO, 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    checkVal("post reset idle", {31'b0, DivDone}, 32'd0);

    runDiv("1000/-7",   32'd1000,      32'hFFFFFFF9,  32'hFFFFFF72,  32'd6,         1'b0, 1'b0, 34, 0, 0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
